demux1to4_tdm: RTL
==================

// Module: demux1to4_tdm
// PURPOSE
//  Receive end of a 4-slot time-division link: one W-bit sample stream in, four
//  parallel channels out (inverse of the 4:1 select path, s1s0 = 00/01/10/11 -> y0..y3).
//  A slot counter replaces the select inputs. It is aligned by a frame-sync flag
//  and advances on each accepted sample. A completed frame is published on
//  y0..y3 together with a one-cycle frame_valid pulse.
// PARAMETERS
//  W  8  sample / channel width in bits
// PORTS
//  clk          in   1  single clock, all state updates on rising edge
//  rst_n        in   1  asynchronous reset, active-low
//  din          in   W  serial-slot sample
//  din_valid    in   1  din is a valid sample this cycle (accept = din_valid)
//  sync         in   1  qualifies din as slot 0 (s1s0=00); ignored when din_valid=0
//  y0..y3       out  W  registered channel outputs for slots 0..3
//  frame_valid  out  1  1-cycle pulse: y0..y3 updated with a complete frame
//  slot         out  2  slot index expected for the next accepted sample
//  locked       out  1  1 = frame alignment acquired
//  sync_err     out  1  1-cycle pulse on an alignment error (SYNC_CHECK_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): y0..y3=0, frame_valid=0, slot=0, locked=0, sync_err=0,
//  shadow regs sh0..sh2=0, FSM=HUNT. No sample is accepted while rst_n=0.
//  din_valid=0: all state holds, frame_valid/sync_err go 0.
//  FSM HUNT: samples without sync are discarded. Sample with sync -> sh0<=din, slot<=1, LOCKED.
//  FSM LOCKED, accepted sample:
//   - sync=1 (any slot): sh0<=din, slot<=1. A partial frame is discarded, not published.
//   - sync=0, slot 1..2: sh[slot]<=din, slot<=slot+1.
//   - sync=0, slot 3: y0<=sh0, y1<=sh1, y2<=sh2, y3<=din, frame_valid<=1 next cycle,
//     slot<=0 (wrap). Latency: last sample to outputs = 1 clk.
//   - sync=0, slot 0: see CONFIGURATION.
//  y0..y3 change only on frame completion; they hold between frames and across resync.
//  Slot counter wraps modulo 4 (3->0); it never advances without an accepted sample.
//  Reset mid-frame: the partial frame is lost, outputs clear to 0, and re-lock needs sync.
// CONFIGURATION
//  SYNC_CHECK_EN defined: in LOCKED, a sample at slot 0 must carry sync.
//   - Missing sync at slot 0 -> sample discarded, sync_err=1 for 1 cycle, FSM->HUNT, locked=0.
//   - sync at slot 1..3 (early resync) -> realign as above and pulse sync_err.
//  SYNC_CHECK_EN undefined: after lock, sync is needed only for realignment.
//   - A slot-0 sample without sync is stored in sh0 (free-running).
//   - sync_err is tied to 0. locked falls only on reset.
// STRUCTURE
//  Shared defs include (demux_defs.vh): NCH=4, SLOT_W=2, state codes ST_HUNT=1'b0, ST_LOCKED=1'b1.
//  One sub-module: tdm_slot_tracker (HUNT/LOCKED FSM + 2-bit slot counter; outputs slot,
//  locked, wr_en per shadow reg, publish, sync_err). The top holds the shadow and output regs.
// TESTING
//  1 Reset: rst_n=0 mid-run -> all outputs 0 immediately (async), locked=0.
//  2 Lock+frame: sync with din=A1, then B2,C3,D4 consecutively -> 1 clk after D4: y0..y3=A1,B2,C3,D4,
//    frame_valid=1 for exactly 1 cycle.
//  3 Gaps: same frame with din_valid=0 for 2 cycles between samples -> identical result, slot holds.
//  4 Hunt: 5 samples without sync after reset -> locked=0, outputs stay 0, no frame_valid.
//  5 Early resync: sync,11,22, then sync,33,44,55,66 -> first frame dropped; y=33,44,55,66;
//    sync_err pulse at the second sync iff SYNC_CHECK_EN.
//  6 Missing sync at slot 0 after one good frame -> SYNC_CHECK_EN: sync_err=1, locked=0, HUNT;
//    otherwise: the sample lands in y0 of the next published frame.

Source files
------------

// File: rtl/demux1to4_tdm_pkg.sv
// Shared definitions for the 4-slot TDM receive demux: channel count, slot width, FSM codes.
// Pure definitions; no logic, no latency, no flow control.
// Imported by tdm_slot_tracker and demux1to4_tdm.
package demux1to4_tdm_pkg;

    localparam int NCH    = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/demux1to4_tdm_slot_tracker.sv
// Slot tracker: HUNT/LOCKED alignment FSM plus slot counter; strict slot-0 sync check under SYNC_CHECK_EN.
// wr_en/publish are combinational for the sample in flight; slot/locked/sync_err are registered.
// No backpressure: every din_valid cycle is consumed; idle cycles freeze all state.
module tdm_slot_tracker
    import demux1to4_tdm_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           din_valid,
    input  logic           sync,
    output slot_t          slot,
    output logic           locked,
    output logic [NCH-2:0] wr_en,
    output logic           publish,
    output logic           sync_err
);

    state_t state;

    assign locked = (state == ST_LOCKED);

    always_comb begin
        wr_en   = '0;
        publish = 1'b0;
        if (din_valid) begin
            if (sync) begin
                wr_en[0] = 1'b1;
            end else if (state == ST_LOCKED) begin
                case (slot)
                    2'd1:    wr_en[1] = 1'b1;
                    2'd2:    wr_en[2] = 1'b1;
                    2'd3:    publish  = 1'b1;
                    default: begin
`ifndef SYNC_CHECK_EN
                        wr_en[0] = 1'b1;
`endif
                    end
                endcase
            end
        end
    end

`ifndef SYNC_CHECK_EN
    assign sync_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HUNT;
            slot     <= '0;
`ifdef SYNC_CHECK_EN
            sync_err <= 1'b0;
`endif
        end else begin
`ifdef SYNC_CHECK_EN
            sync_err <= 1'b0;
`endif
            if (din_valid) begin
                if (sync) begin
`ifdef SYNC_CHECK_EN
                    // A sync anywhere but slot 0 means the far end slipped.
                    if (state == ST_LOCKED && slot != 2'd0)
                        sync_err <= 1'b1;
`endif
                    state <= ST_LOCKED;
                    slot  <= 2'd1;
                end else if (state == ST_LOCKED) begin
                    if (slot != 2'd0) begin
                        slot <= slot + 2'd1;
                    end else begin
`ifdef SYNC_CHECK_EN
                        state    <= ST_HUNT;
                        sync_err <= 1'b1;
`else
                        slot     <= 2'd1;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: rtl/demux1to4_tdm.sv
// 4-slot TDM receive demux: serial samples into y0..y3; strict sync checking when SYNC_CHECK_EN is defined.
// Latency: last sample of a frame to y0..y3 and frame_valid is 1 clk.
// No backpressure: a sample is accepted whenever din_valid=1.
module demux1to4_tdm
    import demux1to4_tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         sync,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic         frame_valid,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         sync_err
);

    logic [NCH-2:0] wr_en;
    logic           publish;
    logic [W-1:0]   sh [NCH-1];

    tdm_slot_tracker u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (din_valid),
        .sync      (sync),
        .slot      (slot),
        .locked    (locked),
        .wr_en     (wr_en),
        .publish   (publish),
        .sync_err  (sync_err)
    );

    // Slot 3 is never shadowed: it goes straight from din to y3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH-1; i++)
                sh[i] <= '0;
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NCH-1; i++)
                if (wr_en[i])
                    sh[i] <= din;
            frame_valid <= publish;
            if (publish) begin
                y0 <= sh[0];
                y1 <= sh[1];
                y2 <= sh[2];
                y3 <= din;
            end
        end
    end

endmodule
